// File: rtl/seq_pkg.sv
// Shared types and the PC target helper for the LUT program sequencer.
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  localparam int PC_W_DEF  = 9;
  localparam int IMM_W_DEF = 16;

  // The caller truncates the result to its PC width, so a relative branch
  // wraps modulo 2^PC_W and a negative immediate behaves as signed.
  function automatic logic [31:0] next_pc(input logic [31:0] pc,
                                          input logic [31:0] imm,
                                          input logic        jump,
                                          input logic        br_taken);
    if (jump)          return imm;
    else if (br_taken) return pc + imm;
    else               return pc + 32'd1;
  endfunction

endpackage

// File: rtl/lut_seq_counters.sv
// RUN-cycle and committed-instruction counters; built only with SEQ_CYCLE_CNT_EN.
module lut_seq_counters (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear_i,
  input  logic        run_i,
  input  logic        commit_i,
  output logic [15:0] cycle_cnt_o,
  output logic [15:0] instr_cnt_o
);

  logic [15:0] cycle_cnt_q;
  logic [15:0] instr_cnt_q;

  // run_i is low outside RUN, so both counts freeze in DONE.
  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
    end else if (run_i) begin
      if (cycle_cnt_q != 16'hFFFF) cycle_cnt_q <= cycle_cnt_q + 16'd1;
      if (commit_i && instr_cnt_q != 16'hFFFF) instr_cnt_q <= instr_cnt_q + 16'd1;
    end
  end

  assign cycle_cnt_o = cycle_cnt_q;
  assign instr_cnt_o = instr_cnt_q;

endmodule

// File: rtl/lut_pc_sequencer.sv
// PC sequencer for the 9-bit instruction LUT decoder: IDLE/RUN/DONE FSM and PC.
// Optional RUN/commit counters are enabled by defining SEQ_CYCLE_CNT_EN.
module lut_pc_sequencer
  import seq_pkg::*;
#(
  parameter int PC_W     = PC_W_DEF,
  parameter int IMM_W    = IMM_W_DEF,
  parameter int START_PC = 0,
  parameter int MAX_PC   = 511
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic             stall_i,
  input  logic             jump_i,
  input  logic             branch_i,
  input  logic             cond_i,
  input  logic             halt_i,
  input  logic [IMM_W-1:0] imm_pc_i,
  output logic [PC_W-1:0]  pc_o,
  output logic             busy_o,
  output logic             commit_o,
  output logic             done_o,
  output seq_state_t       state_o
`ifdef SEQ_CYCLE_CNT_EN
  ,
  output logic [15:0]      cycle_cnt_o,
  output logic [15:0]      instr_cnt_o
`endif
);

  localparam logic [PC_W-1:0] START_PC_L = PC_W'(START_PC);
  localparam logic [PC_W-1:0] MAX_PC_L   = PC_W'(MAX_PC);

  seq_state_t      state_q;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;
  logic            busy_q;
  logic            done_q;
  logic            br_taken;
  logic            start_acc;

  assign br_taken  = branch_i & cond_i;
  assign start_acc = start_i & (state_q != RUN);
  assign pc_d      = PC_W'(next_pc(32'(pc_q), 32'(imm_pc_i), jump_i, br_taken));

  // Priority inside RUN: stall, halt, jump, taken branch, fall-through.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= START_PC_L;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start_i) begin
            state_q <= RUN;
            pc_q    <= START_PC_L;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        RUN: begin
          if (stall_i) begin
            state_q <= RUN;
          end else if (halt_i) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (!jump_i && !br_taken && pc_q == MAX_PC_L) begin
            // Only sequential fall-through ends the program at MAX_PC.
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            pc_q <= pc_d;
          end
        end
        default: begin
          state_q <= IDLE;
          pc_q    <= START_PC_L;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign pc_o     = pc_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign state_o  = state_q;
  assign commit_o = busy_q & ~stall_i;

`ifdef SEQ_CYCLE_CNT_EN
  lut_seq_counters u_counters (
    .clk         (clk),
    .reset       (reset),
    .clear_i     (start_acc),
    .run_i       (busy_q),
    .commit_i    (commit_o),
    .cycle_cnt_o (cycle_cnt_o),
    .instr_cnt_o (instr_cnt_o)
  );
`else
  logic unused_start_acc;
  assign unused_start_acc = start_acc;
`endif

endmodule

// File: tb/tb_lut_pc_sequencer.sv
// Scoreboard bench for lut_pc_sequencer: directed per-cycle vectors, negedge monitor.
module tb_lut_pc_sequencer;
  import seq_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_i, stall_i, jump_i, branch_i, cond_i, halt_i;
  logic [15:0] imm_pc_i;
  logic [8:0]  pc_o;
  logic        busy_o, commit_o, done_o;
  seq_state_t  state_o;
`ifdef SEQ_CYCLE_CNT_EN
  logic [15:0] cycle_cnt_o, instr_cnt_o;
  logic [31:0] cnt_q[$];
  logic [15:0] m_cyc = '0;
  logic [15:0] m_ins = '0;
`endif

  // Observation word: {pc, busy, commit, done, state}
  logic [13:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  lut_pc_sequencer dut (
    .clk      (clk),
    .reset    (reset),
    .start_i  (start_i),
    .stall_i  (stall_i),
    .jump_i   (jump_i),
    .branch_i (branch_i),
    .cond_i   (cond_i),
    .halt_i   (halt_i),
    .imm_pc_i (imm_pc_i),
    .pc_o     (pc_o),
    .busy_o   (busy_o),
    .commit_o (commit_o),
    .done_o   (done_o),
    .state_o  (state_o)
`ifdef SEQ_CYCLE_CNT_EN
    ,
    .cycle_cnt_o (cycle_cnt_o),
    .instr_cnt_o (instr_cnt_o)
`endif
  );

  // One cycle: expected outputs of the current cycle, then inputs for the next edge.
  task automatic cyc(input logic rst, input logic st, input logic sl, input logic j,
                     input logic b, input logic c, input logic h, input logic [15:0] imm,
                     input logic [8:0] e_pc, input seq_state_t e_st);
    logic e_busy, e_done, e_commit;
    @(posedge clk);
    #1;
    reset = rst; start_i = st; stall_i = sl; jump_i = j;
    branch_i = b; cond_i = c; halt_i = h; imm_pc_i = imm;
    e_busy   = (e_st == RUN);
    e_done   = (e_st == DONE);
    e_commit = e_busy & ~sl;
    exp_q.push_back({e_pc, e_busy, e_commit, e_done, e_st});
`ifdef SEQ_CYCLE_CNT_EN
    cnt_q.push_back({m_cyc, m_ins});
    if (rst || (st && e_st != RUN)) begin
      m_cyc = '0;
      m_ins = '0;
    end else if (e_busy) begin
      if (m_cyc != 16'hFFFF) m_cyc = m_cyc + 16'd1;
      if (e_commit && m_ins != 16'hFFFF) m_ins = m_ins + 16'd1;
    end
`endif
  endtask

  always @(negedge clk) begin
    logic [13:0] e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {pc_o, busy_o, commit_o, done_o, state_o};
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL outputs vec %0d: got pc=%0d busy=%b commit=%b done=%b st=%0d, want pc=%0d busy=%b commit=%b done=%b st=%0d",
                 vectors, a[13:5], a[4], a[3], a[2], a[1:0], e[13:5], e[4], e[3], e[2], e[1:0]);
      end
`ifdef SEQ_CYCLE_CNT_EN
      begin
        logic [31:0] ce;
        ce = cnt_q.pop_front();
        vectors++;
        if ({cycle_cnt_o, instr_cnt_o} !== ce) begin
          miscompares++;
          $display("FAIL counters vec %0d: got cyc=%0d instr=%0d, want cyc=%0d instr=%0d",
                   vectors, cycle_cnt_o, instr_cnt_o, ce[31:16], ce[15:0]);
        end
      end
`endif
    end
  end

  initial begin
    reset = 1'b1; start_i = 0; stall_i = 0; jump_i = 0;
    branch_i = 0; cond_i = 0; halt_i = 0; imm_pc_i = '0;
    repeat (2) @(posedge clk);
    // rst st sl j b c h imm         pc   state
    cyc(0, 1, 0, 0, 0, 0, 0, 16'h0000, 9'd0, IDLE);
    cyc(0, 0, 0, 0, 0, 0, 0, 16'h0000, 9'd0, RUN);
    cyc(0, 0, 0, 0, 0, 0, 0, 16'h0000, 9'd1, RUN);
    cyc(0, 0, 0, 0, 0, 0, 0, 16'h0000, 9'd2, RUN);
    cyc(0, 0, 0, 0, 0, 0, 0, 16'h0000, 9'd3, RUN);
    cyc(0, 0, 0, 0, 0, 0, 0, 16'h0000, 9'd4, RUN);
    cyc(0, 0, 0, 1, 0, 0, 0, 16'h0040, 9'd5, RUN);
    cyc(0, 0, 0, 0, 1, 1, 0, 16'hFFFE, 9'd64, RUN);
    cyc(0, 0, 0, 0, 1, 0, 0, 16'hFFFE, 9'd62, RUN);
    cyc(0, 0, 0, 1, 0, 0, 0, 16'h0007, 9'd63, RUN);
    cyc(0, 0, 1, 1, 0, 0, 1, 16'h0000, 9'd7, RUN);
    cyc(0, 0, 1, 1, 0, 0, 1, 16'h0000, 9'd7, RUN);
    cyc(0, 0, 1, 1, 0, 0, 1, 16'h0000, 9'd7, RUN);
    cyc(0, 0, 0, 0, 0, 0, 1, 16'h0000, 9'd7, RUN);
    cyc(0, 1, 0, 0, 0, 0, 0, 16'h0000, 9'd7, DONE);
    cyc(0, 0, 0, 1, 0, 0, 0, 16'd508,  9'd0, RUN);
    cyc(0, 0, 0, 0, 0, 0, 0, 16'h0000, 9'd508, RUN);
    cyc(0, 0, 0, 1, 1, 1, 0, 16'd510,  9'd509, RUN);
    cyc(0, 0, 0, 0, 0, 0, 0, 16'h0000, 9'd510, RUN);
    cyc(0, 0, 0, 0, 0, 0, 0, 16'h0000, 9'd511, RUN);
    cyc(0, 0, 0, 0, 0, 0, 0, 16'h0000, 9'd511, DONE);
    cyc(0, 1, 0, 0, 0, 0, 0, 16'h0000, 9'd511, DONE);
    cyc(0, 0, 0, 1, 0, 0, 0, 16'd20,   9'd0, RUN);
    cyc(0, 1, 0, 0, 0, 0, 0, 16'h0000, 9'd20, RUN);
    cyc(1, 0, 0, 0, 0, 0, 0, 16'h0000, 9'd21, RUN);
    cyc(0, 1, 0, 0, 0, 0, 0, 16'h0000, 9'd0, IDLE);
    cyc(0, 0, 0, 0, 0, 0, 0, 16'h0000, 9'd0, RUN);
    cyc(0, 0, 1, 0, 0, 0, 0, 16'h0000, 9'd1, RUN);
    cyc(0, 0, 1, 0, 0, 0, 0, 16'h0000, 9'd1, RUN);
    cyc(0, 0, 0, 0, 0, 0, 0, 16'h0000, 9'd1, RUN);
    cyc(0, 0, 0, 0, 0, 0, 0, 16'h0000, 9'd2, RUN);
    cyc(0, 0, 0, 1, 0, 0, 1, 16'd100,  9'd3, RUN);
    cyc(0, 0, 0, 0, 0, 0, 0, 16'h0000, 9'd3, DONE);
    cyc(0, 0, 0, 0, 0, 0, 0, 16'h0000, 9'd3, DONE);
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
